stream_jointer: RTL

- Parametrised successor to the two-way buffer/matrix data select: joins NUM_SRC streams of DATA_SIZE x COLUMN_SIZE row vectors onto one output row bus.
- Adds per-source valid/ready handshakes, fixed-priority or round-robin arbitration, a software force-select, and a one-deep registered output stage.
- Sits between the matrix units / row buffers and the downstream accumulator stage.

---
 rtl/stream_jointer_pkg.sv | 24 ++
 rtl/stream_jointer_rr_arbiter.sv | 31 +++
 rtl/stream_jointer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/stream_jointer_pkg.sv
// Shared constants and helpers for the stream jointer family.
// Contains the arbitration mode encodings and index conversion utilities.
package stream_jointer_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   MAX_SRC    = 16;
   localparam int   MAX_SEL_W  = 4;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // OR-reduction form keeps this a flat encoder when the input is one-hot.
   function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
      logic [MAX_SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_SRC; i++) begin
         if (oh[i]) idx = idx | MAX_SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/stream_jointer_rr_arbiter.sv
// Combinational one-hot arbiter: fixed lowest-index priority or circular
// search starting at ptr. Reusable by any jointer with a request vector.
module rr_arbiter
   import stream_jointer_pkg::*;
#(
   parameter  int NUM_SRC = 4,
   localparam int SEL_W   = sel_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   input  logic               mode,
   output logic [NUM_SRC-1:0] gnt
);

   logic [NUM_SRC-1:0] upper;
   logic [NUM_SRC-1:0] low_all;
   logic [NUM_SRC-1:0] low_upper;

   always_comb begin
      upper = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         upper[i] = req[i] && (i >= int'(ptr));
      end
   end

   // Requests at or above ptr win first; otherwise the search wraps to index 0.
   assign low_all   = req & (~req + NUM_SRC'(1));
   assign low_upper = upper & (~upper + NUM_SRC'(1));
   assign gnt       = ((mode == MODE_RR) && (|upper)) ? low_upper : low_all;

endmodule

// File: rtl/stream_jointer.sv
// Joins NUM_SRC row streams onto one registered output row with arbitration.
// Optional packet locking is enabled by defining STREAM_JOINTER_HOLD_LAST_EN.
module stream_jointer
   import stream_jointer_pkg::*;
#(
   parameter  int DATA_SIZE   = 16,
   parameter  int COLUMN_SIZE = 64,
   parameter  int NUM_SRC     = 4,
   localparam int SEL_W       = sel_width(NUM_SRC),
   localparam int ROW_W       = DATA_SIZE * COLUMN_SIZE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic                     force_en,
   input  logic [SEL_W-1:0]         force_sel,
   input  logic [NUM_SRC-1:0]       in_valid,
   output logic [NUM_SRC-1:0]       in_ready,
   input  logic [NUM_SRC*ROW_W-1:0] in_data,
`ifdef STREAM_JOINTER_HOLD_LAST_EN
   input  logic [NUM_SRC-1:0]       in_last,
   output logic                     out_last,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ROW_W-1:0]         out_data,
   output logic [SEL_W-1:0]         out_src
);

   logic               load;
   logic               xfer;
   logic [NUM_SRC-1:0] force_mask;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] gnt;
   logic [SEL_W-1:0]   rr_ptr;
   logic [SEL_W-1:0]   xfer_idx;
   logic [ROW_W-1:0]   xfer_row;

   assign load = !out_valid || out_ready;

   // An out-of-range force_sel leaves the mask empty, so nothing is granted.
   always_comb begin
      force_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         force_mask[i] = (int'(force_sel) == i);
      end
   end

`ifdef STREAM_JOINTER_HOLD_LAST_EN
   logic               locked;
   logic               locked_next;
   logic [SEL_W-1:0]   lock_src;
   logic [SEL_W-1:0]   lock_src_next;
   logic [NUM_SRC-1:0] lock_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked   <= 1'b0;
         lock_src <= '0;
      end else begin
         locked   <= locked_next;
         lock_src <= lock_src_next;
      end
   end

   always_comb begin
      locked_next   = locked;
      lock_src_next = lock_src;
      if (xfer) begin
         locked_next   = !in_last[xfer_idx];
         lock_src_next = xfer_idx;
      end
   end

   always_comb begin
      lock_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         lock_mask[i] = (int'(lock_src) == i);
      end
   end

   // While a packet is open, force controls are ignored so packets never interleave.
   assign elig = locked   ? (in_valid & lock_mask)
               : force_en ? (in_valid & force_mask)
               :            in_valid;
`else
   assign elig = force_en ? (in_valid & force_mask) : in_valid;
`endif

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .req  (elig),
      .ptr  (rr_ptr),
      .mode (mode),
      .gnt  (gnt)
   );

   assign in_ready = (rst || !load) ? '0 : gnt;
   assign xfer     = |in_ready;
   assign xfer_idx = SEL_W'(onehot_to_idx(MAX_SRC'(in_ready)));
   assign xfer_row = in_data[int'(xfer_idx)*ROW_W +: ROW_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
`ifdef STREAM_JOINTER_HOLD_LAST_EN
         out_last  <= 1'b0;
`endif
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= xfer_row;
            out_src  <= xfer_idx;
`ifdef STREAM_JOINTER_HOLD_LAST_EN
            out_last <= in_last[xfer_idx];
`endif
         end
      end
   end

   // Pointer advances in both modes so switching to round-robin starts fairly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (xfer_idx == SEL_W'(NUM_SRC-1)) ? '0 : xfer_idx + 1'b1;
      end
   end

endmodule
